// File: rtl/fetch_unit.sv
// Instruction fetch stage: requests one 16-bit word at a time, holds it for decode,
// and handles redirects, squashes, HALT and misaligned-target errors.
module fetch_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] next_pc,
   input  logic        redirect,
   input  logic        if_ready,
   input  logic [15:0] mem_data_in,
   input  logic        mem_stall,
   input  logic        mem_done,
   output logic        mem_rd,
   output logic [15:0] mem_addr,
   output logic        if_valid,
   output logic [15:0] if_instr,
   output logic [15:0] if_pc,
   output logic [15:0] if_pc_plus2,
   output logic        halted,
   output logic        fetch_err
);

   typedef enum logic [1:0] {StFetch, StWait, StHold, StHalted} state_e;

   state_e      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic        squash_q, squash_d;
   logic        valid_q, valid_d;
   logic [15:0] instr_q, instr_d;
   logic [15:0] ipc_q, ipc_d;
   logic [15:0] ipc2_q, ipc2_d;
   logic        err_q, err_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= StFetch;
         pc_q     <= 16'h0000;
         squash_q <= 1'b0;
         valid_q  <= 1'b0;
         instr_q  <= 16'h0000;
         ipc_q    <= 16'h0000;
         ipc2_q   <= 16'h0002;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         squash_q <= squash_d;
         valid_q  <= valid_d;
         instr_q  <= instr_d;
         ipc_q    <= ipc_d;
         ipc2_q   <= ipc2_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      squash_d = squash_q;
      valid_d  = valid_q;
      instr_d  = instr_q;
      ipc_d    = ipc_q;
      ipc2_d   = ipc2_q;
      err_d    = err_q;

      // A misaligned target is fatal from any live state; PC keeps its old value.
      if (state_q != StHalted && redirect && next_pc[0]) begin
         err_d    = 1'b1;
         valid_d  = 1'b0;
         squash_d = 1'b0;
         state_d  = StHalted;
      end else begin
         unique case (state_q)
            StFetch: begin
               if (redirect) pc_d = next_pc;
               if (!mem_stall) begin
                  state_d  = StWait;
                  squash_d = redirect;
               end
            end
            StWait: begin
               if (redirect) begin
                  pc_d = next_pc;
                  // A redirect alongside mem_done squashes that response immediately.
                  if (mem_done) begin
                     squash_d = 1'b0;
                     state_d  = StFetch;
                  end else begin
                     squash_d = 1'b1;
                  end
               end else if (mem_done) begin
                  if (squash_q) begin
                     squash_d = 1'b0;
                     state_d  = StFetch;
                  end else begin
                     instr_d = mem_data_in;
                     ipc_d   = pc_q;
                     ipc2_d  = pc_q + 16'd2;
                     pc_d    = pc_q + 16'd2;
                     valid_d = 1'b1;
                     state_d = StHold;
                  end
               end
            end
            StHold: begin
               if (redirect) begin
                  pc_d    = next_pc;
                  valid_d = 1'b0;
                  state_d = StFetch;
               end else if (if_ready) begin
                  valid_d = 1'b0;
                  state_d = (instr_q[15:11] == 5'b00000) ? StHalted : StFetch;
               end
            end
            StHalted: begin
               valid_d = 1'b0;
            end
            default: state_d = StHalted;
         endcase
      end
   end

   assign mem_rd      = (state_q == StFetch);
   assign mem_addr    = pc_q;
   assign if_valid    = valid_q;
   assign if_instr    = instr_q;
   assign if_pc       = ipc_q;
   assign if_pc_plus2 = ipc2_q;
   assign halted      = (state_q == StHalted);
   assign fetch_err   = err_q;

endmodule
